fib_request_arbiter: RTL and testbench
======================================

Name: fib_request_arbiter

Overview:
- Shares one Fibonacci generator datapath between NUM_REQ independent requesters.
- Accepts per-requester index requests and arbitrates round-robin.
- Sequences the generator through start/done, and returns the result or an error to the granted requester.
- Sits between client logic and the generator's control unit. It is the only block that drives the generator's go/count inputs.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 32: width of generator result and response data.
- MAX_N, 5'd24: largest index accepted. Larger requests get an error response.
- TIMEOUT, 64: cycles allowed in WAIT before the request is aborted with an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level. Held high until the matching ack.
- req_n  in  NUM_REQ*5  flattened indices. Requester i uses bits [5i+4:5i].
- ack  out  NUM_REQ  one-cycle completion pulse to requester i.
- rsp_data  out  DATA_W  result. Valid only in the cycle ack is high.
- rsp_err  out  1  error flag. Valid only in the cycle ack is high.
- busy  out  1  high in every state except IDLE.
- gen_start  out  1  one-cycle go pulse to the generator.
- gen_n  out  5  index to the generator. Held stable from ISSUE through WAIT.
- gen_done  in  1  generator completion pulse.
- gen_result  in  DATA_W  generator output. Sampled when gen_done=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0.
  - Timeout counter=0; latched n and data = 0.
  - All outputs 0.
  - Reset mid-operation abandons the request with no ack. The generator is not otherwise signalled.
- States: IDLE, ISSUE, WAIT, RESPOND. The state register is registered; all outputs are decoded from registered state and registers.
- IDLE:
  - If any req bit is high, select the first set bit scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
  - Latch grant and that requester's n.
  - If n > MAX_N: latch err=1 and data=0, go to RESPOND. The generator is not started.
  - Otherwise go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE: gen_start=1 for exactly this cycle, gen_n=latched n. Clear the timeout counter, go to WAIT.
- WAIT:
  - If gen_done=1: latch gen_result, err=0, go to RESPOND.
  - Else if counter == TIMEOUT-1: err=1, data=0, go to RESPOND.
  - Else increment counter.
  - If gen_done and timeout coincide, gen_done wins (err=0).
- RESPOND:
  - ack[grant]=1 for exactly one cycle; rsp_data and rsp_err are driven from the latched values.
  - Update rr_ptr = grant+1, wrapping to 0 at NUM_REQ.
  - Go to IDLE.
- Latency:
  - For a request seen in IDLE at edge t: gen_start is high in cycle t+1.
  - ack is high in the cycle after the edge at which gen_done is sampled.
  - An out-of-range request is acked in cycle t+1.
- Requester protocol:
  - A requester must deassert req in the cycle after its ack.
  - If req is still high when IDLE is next evaluated, it counts as a new request, but rr_ptr has already moved past that requester.
  - req dropping after grant does not cancel the request; the ack still issues.
  - req_n changes after grant are ignored.
- gen_done outside WAIT is ignored.
- ack is one-hot or zero; at most one requester is served at a time.
- rsp_data and rsp_err are 0 whenever ack is 0.

Test Plan:
- Single request, bench generator model returns F(n) (F0=0, F1=1) n+3 cycles after gen_start: req[2]=1, n=10 → one gen_start with gen_n=10; ack[2] one cycle with rsp_data=55, rsp_err=0; busy high from grant through RESPOND.
- All four requesters request simultaneously from reset (n=1,2,3,4) → service order 0,1,2,3 with data 1,1,2,3; exactly one gen_start per request.
- Round-robin fairness: after requester 1 is served, req[0] and req[3] are held high → requester 3 is served before requester 0.
- Out-of-range: n=25 with MAX_N=24 → ack in the cycle after grant, rsp_err=1, rsp_data=0; gen_start never asserted.
- Timeout: generator model never returns gen_done → ack with rsp_err=1 exactly 64 WAIT cycles after entry. A late gen_done afterwards is ignored, and the next request completes normally.
- Async reset asserted during WAIT → all outputs 0 immediately, no ack. After release, a new request for n=0 returns rsp_data=0, rsp_err=0.

Source files
------------

// File: rtl/fib_request_arbiter.sv
// fib_request_arbiter: round-robin sharing of one Fibonacci generator among NUM_REQ requesters
module fib_request_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W = 32,
  parameter logic [4:0] MAX_N = 5'd24,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*5-1:0] req_n,
  output logic [NUM_REQ-1:0]   ack,
  output logic [DATA_W-1:0]    rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 gen_start,
  output logic [4:0]           gen_n,
  input  logic                 gen_done,
  input  logic [DATA_W-1:0]    gen_result
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;
  logic [1:0] state, state_d;
  logic [PW-1:0] rr_ptr, rr_ptr_d, grant, grant_d, sel, idx;
  logic [4:0] n_q, n_d, sel_n;
  logic [DATA_W-1:0] data_q, data_d;
  logic err_q, err_d;
  logic [CW-1:0] cnt, cnt_d;
  // first requesting index at or after rr_ptr, wrapping
  always_comb begin
    sel = rr_ptr;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[idx]) sel = idx;
    end
  end
  assign sel_n = req_n[5*int'(sel) +: 5];
  // sequencing: grant, start generator, wait for result or timeout, respond
  always_comb begin
    state_d = state;
    rr_ptr_d = rr_ptr;
    grant_d = grant;
    n_d = n_q;
    data_d = data_q;
    err_d = err_q;
    cnt_d = cnt;
    if (state == IDLE && |req) begin
      grant_d = sel;
      n_d = sel_n;
      data_d = '0;
      err_d = sel_n > MAX_N;
      state_d = sel_n > MAX_N ? RESPOND : ISSUE;
    end else if (state == ISSUE) begin
      cnt_d = '0;
      state_d = WAIT;
    end else if (state == WAIT) begin
      if (gen_done) begin
        data_d = gen_result;
        err_d = 1'b0;
        state_d = RESPOND;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        data_d = '0;
        err_d = 1'b1;
        state_d = RESPOND;
      end else cnt_d = cnt + 1'b1;
    end else if (state == RESPOND) begin
      rr_ptr_d = grant == PW'(NUM_REQ - 1) ? '0 : grant + 1'b1;
      state_d = IDLE;
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      n_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      cnt <= '0;
    end else begin
      state <= state_d;
      rr_ptr <= rr_ptr_d;
      grant <= grant_d;
      n_q <= n_d;
      data_q <= data_d;
      err_q <= err_d;
      cnt <= cnt_d;
    end
  end
  assign busy = state != IDLE;
  assign gen_start = state == ISSUE;
  assign gen_n = n_q;
  assign ack = state == RESPOND ? NUM_REQ'(1) << grant : '0;
  assign rsp_data = state == RESPOND ? data_q : '0;
  assign rsp_err = state == RESPOND && err_q;
endmodule

// File: tb/tb_fib_request_arbiter.sv
// tb_fib_request_arbiter: directed and randomized checks of fib_request_arbiter
module tb_fib_request_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req = '0;
  logic [19:0] req_n = '0;
  logic [3:0] ack;
  logic [31:0] rsp_data;
  logic rsp_err, busy, gen_start;
  logic [4:0] gen_n;
  logic gen_done = 1'b0;
  logic [31:0] gen_result = '0;
  int n_chk = 0;
  int n_fail = 0;
  int rn [4];
  int gen_mode = 0;
  int gs_cnt = 0;
  int gen_cd = 0;
  int gen_ln = 0;
  bit gen_pend = 0;
  int cyc, g0, m_free, m_ack_c, m_grant_c, m_who, m_ptr, m_n, just;
  bit bl, bad, m_busy, m_err, exp_start;
  logic [31:0] m_data;
  logic [3:0] active, exp_ack;

  always #5 clk = ~clk;

  fib_request_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_n(req_n), .ack(ack),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .gen_start(gen_start),
    .gen_n(gen_n), .gen_done(gen_done), .gen_result(gen_result)
  );

  function automatic logic [31:0] fib(input int n);
    logic [31:0] a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_n();
    for (int i = 0; i < 4; i++) req_n[5*i +: 5] = 5'(rn[i]);
  endtask

  task automatic wait_ack(output int c, output bit lo);
    c = 0;
    lo = 0;
    while (ack == 0 && c < 200) begin
      @(negedge clk);
      c++;
      lo = lo | !busy;
    end
  endtask

  // generator model: result F(n) n+3 cycles after gen_start; mode 1 never answers, mode 2 answers after 80 cycles
  initial forever begin
    @(negedge clk);
    gen_done = 1'b0;
    if (gen_start) begin
      gs_cnt++;
      gen_ln = int'(gen_n);
      gen_pend = gen_mode != 1;
      gen_cd = gen_mode == 2 ? 80 : gen_ln + 3;
    end else if (gen_pend) begin
      gen_cd--;
      if (gen_cd == 0) begin
        gen_done = 1'b1;
        gen_pend = 0;
      end
    end
    gen_result = gen_done ? fib(gen_ln) : $urandom;
  end

  initial begin
    for (int i = 0; i < 4; i++) rn[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", gen_start, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_gen_n", gen_n, 0);
    reset = 1'b1;
    @(negedge clk);
    // single request
    rn[2] = 10;
    drive_n();
    req[2] = 1'b1;
    @(negedge clk);
    chk("t1_start", gen_start, 1);
    chk("t1_gen_n", gen_n, 10);
    chk("t1_busy", busy, 1);
    wait_ack(cyc, bl);
    chk("t1_latency", cyc, 14);
    chk("t1_busy_hold", bl, 0);
    chk("t1_ack", ack, 4'b0100);
    chk("t1_data", rsp_data, 55);
    chk("t1_err", rsp_err, 0);
    req[2] = 1'b0;
    @(negedge clk);
    chk("t1_ack_clr", ack, 0);
    chk("t1_idle", busy, 0);
    chk("t1_starts", gs_cnt, 1);
    // all four from reset
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    g0 = gs_cnt;
    for (int i = 0; i < 4; i++) rn[i] = i + 1;
    drive_n();
    req = 4'hF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wait_ack(cyc, bl);
      chk("t2_order", ack, 64'(1) << k);
      chk("t2_data", rsp_data, fib(k + 1));
      chk("t2_err", rsp_err, 0);
      req[k] = 1'b0;
    end
    @(negedge clk);
    chk("t2_starts", gs_cnt - g0, 4);
    // round-robin fairness
    rn[1] = 5;
    drive_n();
    req[1] = 1'b1;
    @(negedge clk);
    wait_ack(cyc, bl);
    chk("t3_r1", ack, 4'b0010);
    chk("t3_r1_data", rsp_data, 5);
    req[1] = 1'b0;
    @(negedge clk);
    rn[0] = 8;
    rn[3] = 9;
    drive_n();
    req[0] = 1'b1;
    req[3] = 1'b1;
    @(negedge clk);
    wait_ack(cyc, bl);
    chk("t3_first", ack, 4'b1000);
    chk("t3_first_data", rsp_data, 34);
    req[3] = 1'b0;
    @(negedge clk);
    wait_ack(cyc, bl);
    chk("t3_second", ack, 4'b0001);
    chk("t3_second_data", rsp_data, 21);
    req[0] = 1'b0;
    // out-of-range index
    @(negedge clk);
    g0 = gs_cnt;
    rn[2] = 25;
    drive_n();
    req[2] = 1'b1;
    @(negedge clk);
    chk("t4_ack", ack, 4'b0100);
    chk("t4_err", rsp_err, 1);
    chk("t4_data", rsp_data, 0);
    chk("t4_no_start", gen_start, 0);
    req[2] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_starts", gs_cnt - g0, 0);
    chk("t4_idle", busy, 0);
    // timeout, then a late gen_done, then a normal request
    gen_mode = 2;
    rn[1] = 7;
    drive_n();
    req[1] = 1'b1;
    @(negedge clk);
    chk("t5_start", gen_start, 1);
    wait_ack(cyc, bl);
    chk("t5_latency", cyc, 65);
    chk("t5_ack", ack, 4'b0010);
    chk("t5_err", rsp_err, 1);
    chk("t5_data", rsp_data, 0);
    req[1] = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      bad = bad | (ack != 0) | busy;
    end
    chk("t5_late_ignored", bad, 0);
    gen_mode = 0;
    rn[0] = 6;
    drive_n();
    req[0] = 1'b1;
    @(negedge clk);
    wait_ack(cyc, bl);
    chk("t5_next_ack", ack, 4'b0001);
    chk("t5_next_data", rsp_data, 8);
    chk("t5_next_err", rsp_err, 0);
    req[0] = 1'b0;
    // asynchronous reset during WAIT
    @(negedge clk);
    rn[3] = 20;
    drive_n();
    req[3] = 1'b1;
    @(negedge clk);
    chk("t6_start", gen_start, 1);
    repeat (3) @(negedge clk);
    chk("t6_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("t6_rst_ack", ack, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_start", gen_start, 0);
    chk("t6_rst_data", rsp_data, 0);
    chk("t6_rst_err", rsp_err, 0);
    chk("t6_rst_gen_n", gen_n, 0);
    req[3] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      bad = bad | (ack != 0) | busy;
    end
    chk("t6_no_ack", bad, 0);
    rn[0] = 0;
    drive_n();
    req[0] = 1'b1;
    @(negedge clk);
    chk("t6_n0_start", gen_start, 1);
    wait_ack(cyc, bl);
    chk("t6_n0_latency", cyc, 4);
    chk("t6_n0_ack", ack, 4'b0001);
    chk("t6_n0_data", rsp_data, 0);
    chk("t6_n0_err", rsp_err, 0);
    req[0] = 1'b0;
    // randomized traffic against a transaction-level timing model
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    m_free = 0;
    m_busy = 0;
    m_ptr = 0;
    m_who = 0;
    m_n = 0;
    m_err = 0;
    m_data = '0;
    m_ack_c = -1;
    m_grant_c = -1;
    active = '0;
    for (int c = 1; c <= 900; c++) begin
      @(negedge clk);
      just = -1;
      if (!m_busy && c - 1 >= m_free && req != 0) begin
        m_who = -1;
        for (int k = 0; k < 4; k++)
          if (m_who < 0 && req[(m_ptr + k) % 4]) m_who = (m_ptr + k) % 4;
        m_n = rn[m_who];
        m_err = m_n > 24;
        m_data = m_err ? 32'd0 : fib(m_n);
        m_grant_c = c;
        m_ack_c = m_err ? c : c + m_n + 4;
        m_ptr = (m_who + 1) % 4;
        m_busy = 1;
      end
      exp_ack = (m_busy && c == m_ack_c) ? 4'(1 << m_who) : 4'd0;
      exp_start = m_busy && !m_err && c == m_grant_c;
      chk("rnd_ack", ack, exp_ack);
      chk("rnd_data", rsp_data, exp_ack != 0 ? m_data : 32'd0);
      chk("rnd_err", rsp_err, exp_ack != 0 && m_err);
      chk("rnd_start", gen_start, exp_start);
      chk("rnd_busy", busy, m_busy);
      if (m_busy && !m_err) chk("rnd_gen_n", gen_n, m_n);
      if (m_busy && c == m_ack_c) begin
        m_busy = 0;
        m_free = c + 1;
        active[m_who] = 1'b0;
        req[m_who] = 1'b0;
        just = m_who;
      end
      if (m_busy && c == m_grant_c) begin
        if ($urandom_range(0, 1) == 1) req[m_who] = 1'b0;
        rn[m_who] = int'($urandom_range(0, 31));
      end
      if (c < 700)
        for (int i = 0; i < 4; i++)
          if (!active[i] && i != just && $urandom_range(0, 3) == 0) begin
            active[i] = 1'b1;
            req[i] = 1'b1;
            rn[i] = int'($urandom_range(0, 27));
          end
      drive_n();
    end
    chk("rnd_drained", active, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
